// File: rtl/pc_adder_pkg.sv
// Shared constants and types for the program-counter incrementer.
package pc_adder_pkg;

    localparam int XLEN_DEFAULT      = 32;
    localparam int PC_INC_NORMAL     = 4;
    localparam int PC_INC_COMPRESSED = 2;

    typedef logic [XLEN_DEFAULT-1:0] pc_t;

endpackage

// File: rtl/pc_adder_if.sv
// Signal bundle between a PC producer and the pc_adder block.
// The master side drives the current PC and the compressed select.
// The slave side (the adder) returns the next PC, the flags and the registered copies.
interface pc_adder_if
    import pc_adder_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);

    logic [XLEN-1:0] pc_in;
    logic            is_compressed;
    logic [XLEN-1:0] pc_out;
    logic            carry_out;
    logic            misaligned;
    logic [XLEN-1:0] pc_out_q;
    logic            wrap_seen;

    modport master (
        output pc_in,
        output is_compressed,
        input  pc_out,
        input  carry_out,
        input  misaligned,
        input  pc_out_q,
        input  wrap_seen
    );

    modport slave (
        input  pc_in,
        input  is_compressed,
        output pc_out,
        output carry_out,
        output misaligned,
        output pc_out_q,
        output wrap_seen
    );

endinterface

// File: rtl/pc_adder_inc_core.sv
// Combinational core of the PC incrementer: sum, carry out of the top bit,
// and an alignment check against the increment currently in use.
// When PC_ADDER_COMPRESSED_EN is defined, is_compressed selects a +2 step;
// otherwise the step is always INC and is_compressed is never looked at.
module pc_inc_core
    import pc_adder_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int INC  = PC_INC_NORMAL
) (
    input  logic [XLEN-1:0] pc_in,
    input  logic            is_compressed,
    output logic [XLEN-1:0] pc_out,
    output logic            carry_out,
    output logic            misaligned
);

    logic [XLEN-1:0] inc;
    logic [XLEN:0]   sum;

`ifdef PC_ADDER_COMPRESSED_EN
    assign inc = is_compressed ? XLEN'(PC_INC_COMPRESSED) : XLEN'(INC);
`else
    // The select is kept as a port but must not influence the result,
    // so an X on it can never reach the outputs.
    logic unused_is_compressed;
    assign unused_is_compressed = is_compressed;
    assign inc = XLEN'(INC);
`endif

    // One extra bit captures the wrap past 2^XLEN-1.
    assign sum        = {1'b0, pc_in} + {1'b0, inc};
    assign pc_out     = sum[XLEN-1:0];
    assign carry_out  = sum[XLEN];

    // Increments are powers of two, so any set bit below the step is a misalignment.
    // The sum itself is never masked.
    assign misaligned = |(pc_in & (inc - XLEN'(1)));

endmodule

// File: rtl/pc_adder.sv
// Program-counter adder top: wraps the combinational incrementer and adds a
// registered copy of the next PC plus a sticky wrap flag.
// Optional feature macro: PC_ADDER_COMPRESSED_EN (enables the +2 step).
module pc_adder
    import pc_adder_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int INC  = PC_INC_NORMAL
) (
    input logic         clk,
    input logic         rst,
    pc_adder_if.slave   bus
);

    logic [XLEN-1:0] next_pc;
    logic            carry;
    logic            misalign;
    logic [XLEN-1:0] pc_q;
    logic            wrap_q;

    pc_inc_core #(
        .XLEN (XLEN),
        .INC  (INC)
    ) u_core (
        .pc_in         (bus.pc_in),
        .is_compressed (bus.is_compressed),
        .pc_out        (next_pc),
        .carry_out     (carry),
        .misaligned    (misalign)
    );

    // Register the next PC and accumulate any wrap; reset wins over the update.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= next_pc;
            wrap_q <= wrap_q | carry;
        end
    end

    assign bus.pc_out     = next_pc;
    assign bus.carry_out  = carry;
    assign bus.misaligned = misalign;
    assign bus.pc_out_q   = pc_q;
    assign bus.wrap_seen  = wrap_q;

endmodule

// File: tb/tb_pc_adder.sv
// Self-checking bench for pc_adder: directed corner cases plus randomized
// vectors compared against an arithmetic reference model.
module tb_pc_adder;
    import pc_adder_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    // Reference model state for the registered outputs
    pc_t  exp_q;
    logic exp_wrap;

    pc_adder_if #(.XLEN(32)) bus ();

    pc_adder #(
        .XLEN (32),
        .INC  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint unsigned step_of(logic c);
`ifdef PC_ADDER_COMPRESSED_EN
        return (c === 1'b1) ? 64'd2 : 64'd4;
`else
        return 64'd4;
`endif
    endfunction

    function automatic pc_t ref_pc(pc_t pc, logic c);
        longint unsigned s;
        s = longint'(pc) + step_of(c);
        return pc_t'(s % 64'h1_0000_0000);
    endfunction

    function automatic logic ref_carry(pc_t pc, logic c);
        longint unsigned s;
        s = longint'(pc) + step_of(c);
        return (s >= 64'h1_0000_0000);
    endfunction

    function automatic logic ref_mis(pc_t pc, logic c);
        return ((longint'(pc) % step_of(c)) != 0);
    endfunction

    // Advance one rising edge and update the model from the inputs seen there.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            exp_q    = '0;
            exp_wrap = 1'b0;
        end else begin
            exp_wrap = exp_wrap | ref_carry(bus.pc_in, bus.is_compressed);
            exp_q    = ref_pc(bus.pc_in, bus.is_compressed);
        end
        #1;
    endtask

    task automatic drive(pc_t pc, logic c);
        @(negedge clk);
        bus.pc_in         = pc;
        bus.is_compressed = c;
    endtask

    task automatic test_comb_no_clock();
        // Before the first clock edge: purely combinational result.
        bus.pc_in         = 32'h0000_0000;
        bus.is_compressed = 1'b0;
        #1;
        vectors++;
        if ({bus.pc_out, bus.carry_out, bus.misaligned} !== {32'h0000_0004, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL comb_zero: got pc_out=%h carry=%b mis=%b, want 00000004 0 0",
                     bus.pc_out, bus.carry_out, bus.misaligned);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        vectors++;
        if ({bus.pc_out_q, bus.wrap_seen} !== {32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got pc_out_q=%h wrap=%b, want 00000000 0",
                     bus.pc_out_q, bus.wrap_seen);
        end
        // Combinational path is unaffected by reset.
        drive(32'h0000_1000, 1'b0);
        #1;
        vectors++;
        if ({bus.pc_out, bus.carry_out} !== {32'h0000_1004, 1'b0}) begin
            miscompares++;
            $display("FAIL comb_in_reset: got pc_out=%h carry=%b, want 00001004 0",
                     bus.pc_out, bus.carry_out);
        end
        tick();
        vectors++;
        if ({bus.pc_out_q, bus.wrap_seen} !== {32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_priority: got pc_out_q=%h wrap=%b, want 00000000 0",
                     bus.pc_out_q, bus.wrap_seen);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        pc_t  e;
        drive(32'h0000_1000, 1'b0);
        #1;
        vectors++;
        if ({bus.pc_out, bus.carry_out, bus.misaligned} !== {32'h0000_1004, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL pc_1000: got pc_out=%h carry=%b mis=%b, want 00001004 0 0",
                     bus.pc_out, bus.carry_out, bus.misaligned);
        end
        tick();
        vectors++;
        if ({bus.pc_out_q, bus.wrap_seen} !== {32'h0000_1004, 1'b0}) begin
            miscompares++;
            $display("FAIL reg_1000: got pc_out_q=%h wrap=%b, want 00001004 0",
                     bus.pc_out_q, bus.wrap_seen);
        end
        // Misaligned PC: sum not masked.
        drive(32'h0000_0006, 1'b0);
        #1;
        vectors++;
        if ({bus.pc_out, bus.misaligned} !== {32'h0000_000A, 1'b1}) begin
            miscompares++;
            $display("FAIL mis_6: got pc_out=%h mis=%b, want 0000000a 1",
                     bus.pc_out, bus.misaligned);
        end
        drive(32'h0000_0006, 1'b1);
        #1;
`ifdef PC_ADDER_COMPRESSED_EN
        e = 32'h0000_0008;
        vectors++;
        if ({bus.pc_out, bus.misaligned} !== {e, 1'b0}) begin
            miscompares++;
            $display("FAIL comp_6: got pc_out=%h mis=%b, want %h 0", bus.pc_out, bus.misaligned, e);
        end
`else
        e = 32'h0000_000A;
        vectors++;
        if ({bus.pc_out, bus.misaligned} !== {e, 1'b1}) begin
            miscompares++;
            $display("FAIL comp_ignored_6: got pc_out=%h mis=%b, want %h 1", bus.pc_out, bus.misaligned, e);
        end
        // An unknown select must not leak into the result when the feature is off.
        drive(32'h0000_0006, 1'bx);
        #1;
        vectors++;
        if ({bus.pc_out, bus.carry_out, bus.misaligned} !== {32'h0000_000A, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL x_select: got pc_out=%h carry=%b mis=%b, want 0000000a 0 1",
                     bus.pc_out, bus.carry_out, bus.misaligned);
        end
`endif
        tick();
    endtask

    task automatic test_wrap_and_reset();
        drive(32'hFFFF_FFFC, 1'b0);
        #1;
        vectors++;
        if ({bus.pc_out, bus.carry_out} !== {32'h0000_0000, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_comb: got pc_out=%h carry=%b, want 00000000 1", bus.pc_out, bus.carry_out);
        end
        tick();
        vectors++;
        if ({bus.pc_out_q, bus.wrap_seen} !== {32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_reg: got pc_out_q=%h wrap=%b, want 00000000 1",
                     bus.pc_out_q, bus.wrap_seen);
        end
        // Sticky: stays set with non-wrapping inputs.
        drive(32'h0000_0100, 1'b0);
        tick();
        vectors++;
        if ({bus.pc_out_q, bus.wrap_seen} !== {32'h0000_0104, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_sticky: got pc_out_q=%h wrap=%b, want 00000104 1",
                     bus.pc_out_q, bus.wrap_seen);
        end
        // Reset raised between edges changes nothing until the edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.pc_out_q, bus.wrap_seen} !== {32'h0000_0104, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_before_edge: got pc_out_q=%h wrap=%b, want 00000104 1",
                     bus.pc_out_q, bus.wrap_seen);
        end
        tick();
        vectors++;
        if ({bus.pc_out_q, bus.wrap_seen} !== {32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_clears: got pc_out_q=%h wrap=%b, want 00000000 0",
                     bus.pc_out_q, bus.wrap_seen);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.pc_in = 32'h0000_0010;
        bus.is_compressed = 1'b0;
        tick();
        vectors++;
        if ({bus.pc_out_q, bus.wrap_seen} !== {32'h0000_0014, 1'b0}) begin
            miscompares++;
            $display("FAIL post_rst: got pc_out_q=%h wrap=%b, want 00000014 0",
                     bus.pc_out_q, bus.wrap_seen);
        end
    endtask

    task automatic test_random();
        pc_t  pc;
        logic c;
        for (int i = 0; i < 300; i++) begin
            pc = $urandom;
            if ($urandom_range(0, 9) == 0) pc = 32'hFFFF_FFF0 | pc_t'($urandom_range(0, 15));
            c = 1'($urandom_range(0, 1));
            @(negedge clk);
            bus.pc_in = pc;
            bus.is_compressed = c;
            rst = ($urandom_range(0, 29) == 0);
            #1;
            vectors++;
            if ({bus.pc_out, bus.carry_out, bus.misaligned} !==
                {ref_pc(pc, c), ref_carry(pc, c), ref_mis(pc, c)}) begin
                miscompares++;
                $display("FAIL rand_comb pc=%h c=%b: got %h %b %b, want %h %b %b", pc, c,
                         bus.pc_out, bus.carry_out, bus.misaligned,
                         ref_pc(pc, c), ref_carry(pc, c), ref_mis(pc, c));
            end
            tick();
            vectors++;
            if ({bus.pc_out_q, bus.wrap_seen} !== {exp_q, exp_wrap}) begin
                miscompares++;
                $display("FAIL rand_reg pc=%h c=%b rst=%b: got %h %b, want %h %b", pc, c, rst,
                         bus.pc_out_q, bus.wrap_seen, exp_q, exp_wrap);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        pc_t pc;
        pc = 32'h0000_2000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.pc_in = pc;
            bus.is_compressed = 1'b0;
            tick();
            vectors++;
            if (bus.pc_out_q !== exp_q || bus.pc_out_q !== pc + 32'd4) begin
                miscompares++;
                $display("FAIL b2b_%0d: got pc_out_q=%h, want %h", i, bus.pc_out_q, pc + 32'd4);
            end
            pc = pc + 32'd4;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_q       = '0;
        exp_wrap    = 1'b0;
        rst         = 1'b1;
        test_comb_no_clock();
        test_reset();
        test_directed();
        test_wrap_and_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_adder.md
PC_ADDER -- requirements
Module: pc_adder

Interface
REQ-001 Parameter XLEN, default 32: width of the program-counter datapath.
REQ-002 Parameter INC, default 4: normal instruction increment in bytes.
REQ-003 The block SHALL use one clock and synchronous active-high reset: clk input 1, rising-edge clock for the registered outputs only.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 pc_in  input  XLEN  current program counter.
REQ-006 is_compressed  input  1  selects +2 increment when the compressed feature is compiled in; ignored otherwise.
REQ-007 pc_out  output  XLEN  combinational next sequential PC.
REQ-008 carry_out  output  1  combinational; high when the addition wraps past 2^XLEN-1.
REQ-009 misaligned  output  1  combinational; pc_in not aligned to the active increment.
REQ-010 pc_out_q  output  XLEN  pc_out registered on clk.
REQ-011 wrap_seen  output  1  sticky registered flag, set when carry_out is high at a clock edge.

Function
REQ-012 pc_out SHALL equal (pc_in + INC) mod 2^XLEN, purely combinational, with zero latency and no dependence on clk or rst.
REQ-013 pc_out and carry_out SHALL be valid within one delta/propagation after pc_in changes, even with clk and rst tied off or left unconnected.
REQ-014 carry_out SHALL be bit XLEN of the (XLEN+1)-bit sum; e.g. 0xFFFF_FFFC + 4 gives pc_out 0x0000_0000 and carry_out 1.
REQ-015 With increment 4, misaligned SHALL be (pc_in[1:0] != 0); with increment 2, misaligned SHALL be pc_in[0].
REQ-016 A misaligned pc_in SHALL still produce the arithmetic sum, with no masking of low bits.
REQ-017 On every rising clk edge with rst low, pc_out_q SHALL load pc_out.
REQ-018 On every rising clk edge with rst low, wrap_seen SHALL load wrap_seen OR carry_out.
REQ-019 wrap_seen SHALL remain set until reset.
REQ-020 No X SHALL propagate from is_compressed when the compressed feature is disabled.

Reset
REQ-021 On a rising clk edge with rst high, pc_out_q SHALL clear to 0 and wrap_seen SHALL clear to 0.
REQ-022 Reset has priority over the update for pc_out_q and wrap_seen.
REQ-023 Combinational outputs (pc_out, carry_out, misaligned) SHALL be unaffected by rst.
REQ-024 Reset asserted mid-operation SHALL take effect at the next edge only; outputs hold their values until that edge.

Configuration
REQ-025 The macro PC_ADDER_COMPRESSED_EN SHALL control the compressed (+2) increment.
REQ-026 With PC_ADDER_COMPRESSED_EN defined, the increment SHALL be 2 when is_compressed=1, else INC.
REQ-027 With PC_ADDER_COMPRESSED_EN undefined, the increment SHALL always be INC.
REQ-028 With PC_ADDER_COMPRESSED_EN undefined, is_compressed SHALL remain a port but be functionally ignored.

Structure
REQ-029 The shared package SHALL hold XLEN_DEFAULT (32), PC_INC_NORMAL (4), PC_INC_COMPRESSED (2) and a pc_t typedef of logic [XLEN-1:0].
REQ-030 One sub-module, pc_inc_core (combinational sum, carry and alignment check), is natural; the top SHALL add the registered outputs around it.

Verification
REQ-031 pc_in=0x0000_0000 -> pc_out=0x0000_0004, carry_out=0, misaligned=0, checked after 1 ns with no clock.
REQ-032 pc_in=0x0000_1000 -> pc_out=0x0000_1004, carry_out=0.
REQ-033 pc_in=0xFFFF_FFFC -> pc_out=0x0000_0000, carry_out=1; after one clk edge, wrap_seen=1 and pc_out_q=0.
REQ-034 pc_in=0x0000_0006 -> misaligned=1 and pc_out=0x0000_000A; with the macro defined and is_compressed=1 -> misaligned=0 and pc_out=0x0000_0008.
REQ-035 Wrap set, then rst=1 for one edge -> pc_out_q=0 and wrap_seen=0; rst=0 with pc_in=0x10 -> after the next edge pc_out_q=0x14 and wrap_seen stays 0.
